// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scoreboard
//  Purpose  : Tracks in-flight register writes in the EX, MEM and WB stages
//             of the five-stage pipeline. It decides when the instruction in
//             ID must stall for load-use and jr hazards that forwarding
//             cannot resolve, and publishes a per-register busy vector.
//  Ports    : clk, reset           - clock / synchronous active-high reset
//             ID_*                 - decode fields of the instruction in ID
//             Stall                - combinational ID-stage stall request
//             Busy[NREG]           - bit r set while a write to r is in flight
//             StallCycles[CNT_W]   - saturating count of stalled cycles
//             Overflow             - sticky pending-counter overflow flag
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ID_Valid,
    input  logic             ID_Flush,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_UseRs,
    input  logic             ID_UseRt,
    input  logic             ID_RegWrite,
    input  logic             ID_MemRead,
    input  logic [4:0]       ID_WriteAddress,
    input  logic [2:0]       ID_PCSrc,
    output logic             Stall,
    output logic [NREG-1:0]  Busy,
    output logic [CNT_W-1:0] StallCycles,
    output logic             Overflow
);

    localparam logic [2:0]       C_PCSRC_JR  = 3'b011;
    localparam logic [CNT_W-1:0] C_STALL_MAX = '1;

    // ------------------------------------------------------------------
    // Shadow pipeline slots. The WB slot only needs valid/addr: it is used
    // solely for retirement, never for hazard detection, so its load flag
    // is not kept.
    // ------------------------------------------------------------------
    logic       ex_v_q,    mem_v_q,    wb_v_q;
    logic [4:0] ex_addr_q, mem_addr_q, wb_addr_q;
    logic       ex_ld_q,   mem_ld_q;

    logic       ex_v_d;
    logic [4:0] ex_addr_d;
    logic       ex_ld_d;

    logic       match_ex;
    logic       loaduse;
    logic       jrhaz;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             overflow_q,  overflow_d;
    logic [NREG-1:0]  ovf_set;

    // ------------------------------------------------------------------
    // Hazard detection (purely combinational, zero latency)
    // ------------------------------------------------------------------
    always_comb begin
        match_ex = ex_v_q & (((ex_addr_q == ID_rs) & ID_UseRs) |
                             ((ex_addr_q == ID_rt) & ID_UseRt));

        loaduse  = ex_ld_q & match_ex;

        // ALU producers reach jr through forwarding; only loads that have
        // not yet left MEM leave the jump target unavailable.
        jrhaz    = (ID_PCSrc == C_PCSRC_JR) &
                   ((ex_v_q  & ex_ld_q  & (ex_addr_q  == ID_rs)) |
                    (mem_v_q & mem_ld_q & (mem_addr_q == ID_rs)));

        Stall    = ID_Valid & ~ID_Flush & (loaduse | jrhaz);
    end

    // ------------------------------------------------------------------
    // Next EX slot: a real write to a nonzero register that actually
    // leaves ID this cycle. Stalled or flushed instructions become bubbles.
    // ------------------------------------------------------------------
    always_comb begin
        ex_v_d    = ID_Valid & ~ID_Flush & ~Stall & ID_RegWrite &
                    (ID_WriteAddress != 5'd0);
        ex_addr_d = ex_v_d ? ID_WriteAddress : 5'd0;
        ex_ld_d   = ex_v_d & ID_MemRead;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_v_q     <= 1'b0;
            ex_addr_q  <= 5'd0;
            ex_ld_q    <= 1'b0;
            mem_v_q    <= 1'b0;
            mem_addr_q <= 5'd0;
            mem_ld_q   <= 1'b0;
            wb_v_q     <= 1'b0;
            wb_addr_q  <= 5'd0;
        end else begin
            ex_v_q     <= ex_v_d;
            ex_addr_q  <= ex_addr_d;
            ex_ld_q    <= ex_ld_d;
            mem_v_q    <= ex_v_q;
            mem_addr_q <= ex_addr_q;
            mem_ld_q   <= ex_ld_q;
            wb_v_q     <= mem_v_q;
            wb_addr_q  <= mem_addr_q;
        end
    end

    // ------------------------------------------------------------------
    // Per-register pending counters. r0 is never written, so it has no
    // counter and is permanently not busy.
    // ------------------------------------------------------------------
    generate
        for (genvar r = 0; r < NREG; r++) begin : g_reg
            if (r == 0) begin : g_r0
                assign Busy[r]    = 1'b0;
                assign ovf_set[r] = 1'b0;
            end else begin : g_rn
                logic       inc;
                logic       dec;
                logic [1:0] cnt_q;
                logic [1:0] cnt_d;

                assign inc = ex_v_d & (ex_addr_d == 5'(r));
                assign dec = wb_v_q & (wb_addr_q == 5'(r));

                // Simultaneous insert and retire cancel out, so a full
                // counter only overflows on a net increment.
                always_comb begin
                    cnt_d = cnt_q;
                    if (inc & ~dec) begin
                        if (cnt_q != 2'd3) begin
                            cnt_d = cnt_q + 2'd1;
                        end
                    end else if (dec & ~inc) begin
                        if (cnt_q != 2'd0) begin
                            cnt_d = cnt_q - 2'd1;
                        end
                    end
                end

                assign ovf_set[r] = inc & ~dec & (cnt_q == 2'd3);
                assign Busy[r]    = (cnt_q != 2'd0);

                always_ff @(posedge clk) begin
                    if (reset) begin
                        cnt_q <= 2'd0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Statistics and error flag
    // ------------------------------------------------------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (Stall && (stall_cnt_q != C_STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        overflow_d = overflow_q | (|ovf_set);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    assign StallCycles = stall_cnt_q;
    assign Overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_scoreboard
//  Purpose  : Self-checking bench for hazard_scoreboard. A queue of issued
//             writes stamped with their issue cycle stands in for the
//             pipeline; stage position is derived from the age of each entry.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam int NREG  = 32;
    localparam int CNT_W = 4;
    localparam int unsigned C_MAXC = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             ID_Valid, ID_Flush, ID_UseRs, ID_UseRt;
    logic             ID_RegWrite, ID_MemRead;
    logic [4:0]       ID_rs, ID_rt, ID_WriteAddress;
    logic [2:0]       ID_PCSrc;
    logic             Stall;
    logic [NREG-1:0]  Busy;
    logic [CNT_W-1:0] StallCycles;
    logic             Overflow;

    hazard_scoreboard #(.NREG(NREG), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .ID_Valid        (ID_Valid),
        .ID_Flush        (ID_Flush),
        .ID_rs           (ID_rs),
        .ID_rt           (ID_rt),
        .ID_UseRs        (ID_UseRs),
        .ID_UseRt        (ID_UseRt),
        .ID_RegWrite     (ID_RegWrite),
        .ID_MemRead      (ID_MemRead),
        .ID_WriteAddress (ID_WriteAddress),
        .ID_PCSrc        (ID_PCSrc),
        .Stall           (Stall),
        .Busy            (Busy),
        .StallCycles     (StallCycles),
        .Overflow        (Overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [4:0]  addr;
        logic        ld;
    } rec_t;

    rec_t        inflight[$];
    int unsigned cyc;
    int unsigned m_stallcnt;
    logic        last_stall;
    int          n_checks;
    int          n_fail;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Load-use: a load issued exactly one cycle ago (sitting in EX) writes a
    // source that ID reads. Jr: a load issued one or two cycles ago (EX or
    // MEM) writes the jump register.
    function automatic logic model_stall();
        logic lu = 1'b0;
        logic jr = 1'b0;
        foreach (inflight[i]) begin
            int unsigned age = cyc - inflight[i].cyc;
            if (inflight[i].ld && age == 1 &&
                ((ID_UseRs && inflight[i].addr == ID_rs) ||
                 (ID_UseRt && inflight[i].addr == ID_rt)))
                lu = 1'b1;
            if (inflight[i].ld && (age == 1 || age == 2) &&
                ID_PCSrc == 3'b011 && inflight[i].addr == ID_rs)
                jr = 1'b1;
        end
        return ID_Valid && !ID_Flush && (lu || jr);
    endfunction

    function automatic logic [NREG-1:0] model_busy();
        logic [NREG-1:0] b = '0;
        foreach (inflight[i]) b[inflight[i].addr] = 1'b1;
        return b;
    endfunction

    task automatic idle();
        ID_Valid = 0; ID_Flush = 0; ID_UseRs = 0; ID_UseRt = 0;
        ID_RegWrite = 0; ID_MemRead = 0; ID_rs = 0; ID_rt = 0;
        ID_WriteAddress = 0; ID_PCSrc = 3'b000;
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic rw,
                         input logic mr, input logic [4:0] wa, input logic [2:0] pcs);
        ID_Valid = 1; ID_Flush = 0;
        ID_rs = rs; ID_rt = rt; ID_UseRs = urs; ID_UseRt = urt;
        ID_RegWrite = rw; ID_MemRead = mr; ID_WriteAddress = wa; ID_PCSrc = pcs;
    endtask

    // One clock cycle: check outputs against the model, advance the model,
    // and return at posedge+1 ready for the next input set.
    task automatic step(input string tag);
        logic s;
        #1;
        s = model_stall();
        check_eq({tag, ".stall"}, 64'(Stall), 64'(s));
        check_eq({tag, ".busy"},  64'(Busy), 64'(model_busy()));
        check_eq({tag, ".scnt"},  64'(StallCycles), 64'(m_stallcnt));
        check_eq({tag, ".ovf"},   64'(Overflow), 64'(0));
        last_stall = s;
        if (reset) begin
            inflight.delete();
            m_stallcnt = 0;
        end else begin
            if (ID_Valid && !ID_Flush && !s && ID_RegWrite && ID_WriteAddress != 0)
                inflight.push_back('{cyc, ID_WriteAddress, ID_MemRead});
            if (s && m_stallcnt != C_MAXC) m_stallcnt++;
        end
        @(posedge clk);
        cyc++;
        while (inflight.size() > 0 && (cyc - inflight[0].cyc) > 3) void'(inflight.pop_front());
        #1;
    endtask

    // Hold the current ID instruction until it leaves ID; report stalls.
    task automatic issue(input string tag, output int ns);
        ns = 0;
        for (int k = 0; k < 8; k++) begin
            step(tag);
            if (!last_stall) return;
            ns++;
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s.timeout: observed stall>8 cycles expected release", tag);
    endtask

    initial begin
        int ns;
        n_checks = 0; n_fail = 0; cyc = 0; m_stallcnt = 0; last_stall = 0;
        idle();
        reset = 1;
        @(posedge clk); @(posedge clk); #1;
        check_eq("rst.busy", 64'(Busy), 64'(0));
        check_eq("rst.scnt", 64'(StallCycles), 64'(0));
        check_eq("rst.ovf",  64'(Overflow), 64'(0));
        check_eq("rst.stall", 64'(Stall), 64'(0));
        reset = 0;

        // lw $8 ; add $9,$8,$8
        drive(5'd1, 5'd0, 1, 0, 1, 1, 5'd8, 3'b000); issue("lw8", ns);
        drive(5'd8, 5'd8, 1, 1, 1, 0, 5'd9, 3'b000); issue("lu_add", ns);
        check_eq("lu_nstall", 64'(ns), 64'(1));
        check_eq("lu_scnt", 64'(StallCycles), 64'(1));
        idle(); for (int k = 0; k < 4; k++) step("drain1");

        // lw $8 ; jr $8 -> two stalls
        drive(5'd1, 5'd0, 1, 0, 1, 1, 5'd8, 3'b000); issue("lw8b", ns);
        drive(5'd8, 5'd0, 1, 0, 0, 0, 5'd0, 3'b011); issue("jr8", ns);
        check_eq("jr_nstall", 64'(ns), 64'(2));
        idle(); for (int k = 0; k < 4; k++) step("drain2");

        // lw $8 ; add $2 ; jr $8 -> one stall
        drive(5'd1, 5'd0, 1, 0, 1, 1, 5'd8, 3'b000); issue("lw8c", ns);
        drive(5'd3, 5'd4, 1, 1, 1, 0, 5'd2, 3'b000); issue("add2", ns);
        drive(5'd8, 5'd0, 1, 0, 0, 0, 5'd0, 3'b011); issue("jr8b", ns);
        check_eq("jr1_nstall", 64'(ns), 64'(1));
        idle(); for (int k = 0; k < 4; k++) step("drain3");

        // add/sub/or $8 back-to-back, then drain
        for (int k = 0; k < 3; k++) begin
            drive(5'd1, 5'd2, 1, 1, 1, 0, 5'd8, 3'b000); issue("alu8", ns);
        end
        check_eq("alu8_busy", 64'(Busy[8]), 64'(1));
        idle(); for (int k = 0; k < 4; k++) step("drain4");
        check_eq("alu8_clear", 64'(Busy[8]), 64'(0));

        // lw $0 ; consumer of $0 -> no stall
        drive(5'd1, 5'd0, 1, 0, 1, 1, 5'd0, 3'b000); issue("lw0", ns);
        drive(5'd0, 5'd0, 1, 1, 1, 0, 5'd5, 3'b000); issue("use0", ns);
        check_eq("use0_nstall", 64'(ns), 64'(0));
        idle(); for (int k = 0; k < 4; k++) step("drain5");

        // load-use with flush in the same cycle
        drive(5'd1, 5'd0, 1, 0, 1, 1, 5'd8, 3'b000); issue("lw8d", ns);
        drive(5'd8, 5'd0, 1, 0, 1, 0, 5'd9, 3'b000); ID_Flush = 1; step("flush");
        idle(); step("flush2");
        check_eq("flush_busy9", 64'(Busy[9]), 64'(0));
        for (int k = 0; k < 3; k++) step("drain6");

        // reset during a pending load-use stall
        drive(5'd1, 5'd0, 1, 0, 1, 1, 5'd8, 3'b000); issue("lw8e", ns);
        drive(5'd8, 5'd0, 1, 0, 1, 0, 5'd9, 3'b000); reset = 1; step("rststall");
        reset = 0; step("postrst");
        idle();

        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            int unsigned a;
            reset           = ($urandom_range(0, 99) == 0);
            ID_Valid        = ($urandom_range(0, 9) < 8);
            ID_Flush        = ($urandom_range(0, 9) == 0);
            a = $urandom_range(0, 5); ID_rs = (a == 5) ? 5'd8 : 5'(a);
            a = $urandom_range(0, 5); ID_rt = (a == 5) ? 5'd8 : 5'(a);
            a = $urandom_range(0, 5); ID_WriteAddress = (a == 5) ? 5'd8 : 5'(a);
            ID_UseRs        = 1'($urandom);
            ID_UseRt        = 1'($urandom);
            ID_RegWrite     = ($urandom_range(0, 9) < 7);
            ID_MemRead      = ($urandom_range(0, 9) < 4);
            ID_PCSrc        = ($urandom_range(0, 3) == 0) ? 3'b011 : 3'($urandom_range(0, 2));
            step("rnd");
        end
        reset = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
